// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - N-channel synchronising edge detector with sticky flags and counters
//
// Purpose:
//   Each channel synchronises a raw level, optionally filters it for stability,
//   and produces registered one-cycle rise/fall pulses. A per-channel mode
//   selects which pulses count as events. Events set a sticky flag and advance
//   a saturating counter.
//
// Optional feature:
//   EDGE_DEBOUNCE_EN - when defined, inserts a stability filter of DEBOUNCE_CYC
//   cycles between the synchroniser output and the edge detector.
//
// Ports:
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   in          in   N        raw levels, may be asynchronous to clk
//   mode        in   2*N      ch i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   sticky_clr  in   N        clear sticky[i] (level)
//   cnt_clr     in   N        clear counter of ch i (level)
//   pedge       out  N        raw rising-edge pulse
//   nedge       out  N        raw falling-edge pulse
//   evt         out  N        mode-qualified edge pulse
//   sticky      out  N        evt latched until cleared
//   cnt         out  N*CNT_W  ch i at [i*CNT_W +: CNT_W], saturating event count

module multi_edge_detector #(
  parameter int N            = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int INIT_LEVEL   = 0,
  parameter int CNT_W        = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in,
  input  logic [2*N-1:0]     mode,
  input  logic [N-1:0]       sticky_clr,
  input  logic [N-1:0]       cnt_clr,
  output logic [N-1:0]       pedge,
  output logic [N-1:0]       nedge,
  output logic [N-1:0]       evt,
  output logic [N-1:0]       sticky,
  output logic [N*CNT_W-1:0] cnt
);

  localparam logic INIT_B = (INIT_LEVEL != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifndef EDGE_DEBOUNCE_EN
  // Filter length only matters when the filter is built.
  logic w_unused_db;
  assign w_unused_db = (DEBOUNCE_CYC > 0);
`endif

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic             w_s;
    logic             w_lvl;
    logic             w_pedge_next;
    logic             w_nedge_next;
    logic             w_evt_next;
    logic             r_prev;
    logic             r_pedge;
    logic             r_nedge;
    logic             r_evt;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    // Synchroniser chain; with zero stages the pin feeds the detector directly.
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = in[g];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= {SYNC_STAGES{INIT_B}};
        end else begin
          r_sync[0] <= in[g];
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end

`ifdef EDGE_DEBOUNCE_EN
    // The filtered level follows s only after s has disagreed with it for
    // DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    logic [DB_W-1:0] r_db_cnt;
    logic            r_lvl;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_db_cnt <= '0;
        r_lvl    <= INIT_B;
      end else if (w_s == r_lvl) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        r_lvl    <= w_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
    assign w_lvl = r_lvl;
`else
    assign w_lvl = w_s;
`endif

    assign w_pedge_next = w_lvl & ~r_prev;
    assign w_nedge_next = ~w_lvl & r_prev;
    assign w_evt_next   = (w_pedge_next & mode[2*g]) | (w_nedge_next & mode[2*g+1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prev   <= INIT_B;
        r_pedge  <= 1'b0;
        r_nedge  <= 1'b0;
        r_evt    <= 1'b0;
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_prev   <= w_lvl;
        r_pedge  <= w_pedge_next;
        r_nedge  <= w_nedge_next;
        r_evt    <= w_evt_next;
        // A new event outranks a clear arriving in the same cycle.
        r_sticky <= w_evt_next | (r_sticky & ~sticky_clr[g]);
        // Clear outranks a coincident event, which is then not counted.
        if (cnt_clr[g]) begin
          r_cnt <= '0;
        end else if (w_evt_next && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign pedge[g]                 = r_pedge;
    assign nedge[g]                 = r_nedge;
    assign evt[g]                   = r_evt;
    assign sticky[g]                = r_sticky;
    assign cnt[g*CNT_W +: CNT_W]    = r_cnt;
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb/tb_multi_edge_detector.sv - self-checking bench for multi_edge_detector
module tb_multi_edge_detector;

  localparam int N     = 4;
  localparam int SYNC  = 2;
  localparam int INIT  = 0;
  localparam int CW    = 4;
  localparam int D     = 4;
  localparam int MAXE  = 4000;
`ifdef EDGE_DEBOUNCE_EN
  localparam int LAT   = SYNC + 1 + D;
`else
  localparam int LAT   = SYNC + 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    din;
  logic [2*N-1:0]  mode;
  logic [N-1:0]    sticky_clr;
  logic [N-1:0]    cnt_clr;
  logic [N-1:0]    pedge, nedge, evt, sticky;
  logic [N*CW-1:0] cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  multi_edge_detector #(
    .N(N), .SYNC_STAGES(SYNC), .INIT_LEVEL(INIT), .CNT_W(CW), .DEBOUNCE_CYC(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .mode(mode),
    .sticky_clr(sticky_clr), .cnt_clr(cnt_clr),
    .pedge(pedge), .nedge(nedge), .evt(evt), .sticky(sticky), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // Reference model: sample history since reset release, indexed by edge number.
  logic [N-1:0]    h_mem [0:MAXE];
  logic [N-1:0]    l_mem [0:MAXE];
  int              e;
  logic [N-1:0]    x_pedge, x_nedge, x_evt, x_sticky;
  int              x_cnt [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic init_b();
    return (INIT != 0);
  endfunction

  // Level the synchroniser presents to the detector logic just before edge idx.
  function automatic logic s_at(input int c, input int idx);
    int j;
    j = idx - SYNC;
    if (idx < 1 || j < 1) return init_b();
    return h_mem[j][c];
  endfunction

  function automatic logic lvl_at(input int c, input int idx);
    if (idx < 1) return init_b();
    return l_mem[idx][c];
  endfunction

  task automatic model_reset();
    e        = 0;
    x_pedge  = '0;
    x_nedge  = '0;
    x_evt    = '0;
    x_sticky = '0;
    for (int c = 0; c < N; c++) x_cnt[c] = 0;
  endtask

  task automatic model_edge();
    logic l_now, l_prev, pe, ne, ev;
    bit   all_diff;
    for (int c = 0; c < N; c++) begin
`ifdef EDGE_DEBOUNCE_EN
      if (e == 1) begin
        l_now = init_b();
      end else begin
        l_now = lvl_at(c, e - 1);
        all_diff = 1'b1;
        for (int k = e - D; k <= e - 1; k++) begin
          if (k < 1 || s_at(c, k) == l_now) all_diff = 1'b0;
        end
        if (all_diff) l_now = s_at(c, e - 1);
      end
`else
      l_now = s_at(c, e);
`endif
      l_mem[e][c] = l_now;
      l_prev = lvl_at(c, e - 1);
      pe = l_now & ~l_prev;
      ne = ~l_now & l_prev;
      ev = (pe & mode[2*c]) | (ne & mode[2*c+1]);
      x_pedge[c]  = pe;
      x_nedge[c]  = ne;
      x_evt[c]    = ev;
      x_sticky[c] = ev | (x_sticky[c] & ~sticky_clr[c]);
      if (cnt_clr[c])                    x_cnt[c] = 0;
      else if (ev && x_cnt[c] < (1 << CW) - 1) x_cnt[c] = x_cnt[c] + 1;
    end
  endtask

  function automatic logic [N*CW-1:0] x_cnt_flat();
    logic [N*CW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*CW +: CW] = CW'(x_cnt[c]);
    return v;
  endfunction

  // One clock: inputs were driven at the previous negedge.
  task automatic step();
    @(posedge clk);
    e++;
    h_mem[e] = din;
    model_edge();
    @(negedge clk);
    chk("pedge",  64'(pedge),  64'(x_pedge));
    chk("nedge",  64'(nedge),  64'(x_nedge));
    chk("evt",    64'(evt),    64'(x_evt));
    chk("sticky", 64'(sticky), 64'(x_sticky));
    chk("cnt",    64'(cnt),    64'(x_cnt_flat()));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pedge"},  64'(pedge),  64'd0);
    chk({tag, "_nedge"},  64'(nedge),  64'd0);
    chk({tag, "_evt"},    64'(evt),    64'd0);
    chk({tag, "_sticky"}, 64'(sticky), 64'd0);
    chk({tag, "_cnt"},    64'(cnt),    64'd0);
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      din        = din ^ N'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) mode = (2*N)'($urandom);
      sticky_clr = N'($urandom & $urandom & $urandom);
      cnt_clr    = N'($urandom & $urandom & $urandom & $urandom);
      step();
    end
  endtask

  initial begin
    int lat, width, guard;
    rst_n      = 1'b0;
    din        = '0;
    mode       = '0;
    sticky_clr = '0;
    cnt_clr    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // ch0 rise, ch1 fall, ch2/ch3 both.
    mode = 8'b11_11_10_01;
    for (int i = 0; i < 10; i++) step();

    // Single rising edge on ch0: latency and pulse width.
    din[0] = 1'b1;
    lat    = 0;
    width  = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (pedge[0]) begin
        width++;
        if (lat == 0) lat = i;
      end
    end
    chk("lat_pedge0", 64'(lat), 64'(LAT));
    chk("width_pedge0", 64'(width), 64'd1);

    // ch1 pulse high then low: evt only on the fall.
    din[1] = 1'b1;
    for (int i = 0; i < 12; i++) step();
    din[1] = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("cnt_ch1", 64'(cnt[1*CW +: CW]), 64'd1);
    sticky_clr[1] = 1'b1;
    step();
    sticky_clr[1] = 1'b0;

    // ch2/ch3 toggled long enough to saturate, then clears against live events.
    for (int i = 0; i < 30; i++) begin
      din[2] = ~din[2];
      din[3] = ~din[3];
      step();
    end
    chk("cnt_ch2_sat", 64'(cnt[2*CW +: CW]), 64'((1 << CW) - 1));
    sticky_clr[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din[2] = ~din[2];
      din[3] = ~din[3];
      cnt_clr[2] = (i == 2);
      step();
    end
    cnt_clr    = '0;
    sticky_clr = '0;
    for (int i = 0; i < 12; i++) step();

    random_steps(400);

    // Reset while a pulse is in flight.
    din   = ~din;
    guard = 0;
    while ((pedge | nedge) == '0 && guard < 30) begin
      step();
      guard++;
    end
    chk("pulse_before_reset", 64'(guard < 30), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    din = '1;
    repeat (2) @(negedge clk);
    chk_zero("heldreset");
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    random_steps(300);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
